// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM channel scheduler: FSM state encoding, default
// bus widths and the engine command record.
package sdram_sched_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    NEXT,
    DONE
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/sdram_channel_scheduler.sv
// Per-sample sequencer: one read then one optional write per channel, results published atomically.
// Optional read-data timeout is enabled by defining SDRAM_SCHED_TIMEOUT_EN.
module sdram_channel_scheduler #(
  parameter int NUM    = 16,
  parameter int ADDR_W = sdram_sched_pkg::ADDR_W,
  parameter int DATA_W = sdram_sched_pkg::DATA_W
`ifdef SDRAM_SCHED_TIMEOUT_EN
  ,
  parameter int TMO    = 63
`endif
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic                       start_i,
  input  logic [NUM-1:0][DATA_W-1:0] writedata_i,
  input  logic [NUM-1:0][ADDR_W-1:0] write_address_i,
  input  logic [NUM-1:0]             write_enable_i,
  input  logic [NUM-1:0][ADDR_W-1:0] read_address_i,
  output logic [NUM-1:0][DATA_W-1:0] readdata_o,
  output logic                       ready_o,
  output logic                       overrun_o,
  output logic                       cmd_valid_o,
  input  logic                       cmd_ready_i,
  output logic                       cmd_write_o,
  output logic [ADDR_W-1:0]          cmd_addr_o,
  output logic [DATA_W-1:0]          cmd_wdata_o,
  input  logic                       rd_valid_i,
  input  logic [DATA_W-1:0]          rd_data_i,
  output logic                       timeout_o
);
  import sdram_sched_pkg::*;

  localparam int              CH_W    = $clog2(NUM);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM - 1);

  state_t                     state, nxt;
  logic [CH_W-1:0]            ch;
  logic [NUM-1:0][DATA_W-1:0] shadow;
  logic                       tmo_hit;

`ifdef SDRAM_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == RD_WAIT) && !rd_valid_i && (tmo_cnt == TMO_W'(TMO - 1));

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state == RD_REQ && cmd_ready_i) tmo_cnt <= '0;
      else if (state == RD_WAIT)          tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) timeout_o <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // WR_REQ spends one cycle deciding/loading the write, then holds it until accepted.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_i) nxt = RD_REQ;
      RD_REQ:  if (cmd_ready_i) nxt = RD_WAIT;
      RD_WAIT: if (rd_valid_i || tmo_hit) nxt = WR_REQ;
      WR_REQ:  if (cmd_valid_o ? cmd_ready_i : !write_enable_i[ch]) nxt = NEXT;
      NEXT:    nxt = (ch == CH_LAST) ? DONE : RD_REQ;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state       <= IDLE;
      ch          <= '0;
      ready_o     <= 1'b1;
      overrun_o   <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_write_o <= 1'b0;
      cmd_addr_o  <= '0;
      cmd_wdata_o <= '0;
      shadow      <= '0;
      readdata_o  <= '0;
    end else begin
      state <= nxt;
      if (start_i && !ready_o) overrun_o <= 1'b1;
      case (state)
        IDLE: if (start_i) begin
          ready_o     <= 1'b0;
          ch          <= '0;
          cmd_valid_o <= 1'b1;
          cmd_write_o <= 1'b0;
          cmd_addr_o  <= read_address_i[0];
        end
        RD_REQ: if (cmd_ready_i) cmd_valid_o <= 1'b0;
        RD_WAIT: begin
          if (rd_valid_i)   shadow[ch] <= rd_data_i;
          else if (tmo_hit) shadow[ch] <= '0;
        end
        WR_REQ: begin
          if (cmd_valid_o) begin
            if (cmd_ready_i) cmd_valid_o <= 1'b0;
          end else if (write_enable_i[ch]) begin
            cmd_valid_o <= 1'b1;
            cmd_write_o <= 1'b1;
            cmd_addr_o  <= write_address_i[ch];
            cmd_wdata_o <= writedata_i[ch];
          end
        end
        NEXT: if (ch != CH_LAST) begin
          ch          <= ch + 1'b1;
          cmd_valid_o <= 1'b1;
          cmd_write_o <= 1'b0;
          cmd_addr_o  <= read_address_i[ch + 1'b1];
        end
        DONE: begin
          readdata_o <= shadow;
          ready_o    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_channel_scheduler.sv
// Directed bench for sdram_channel_scheduler (NUM=4) with a 2-cycle read-latency engine model.
`timescale 1ns/1ps
module tb_sdram_channel_scheduler;
  localparam int NUM    = 4;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;

  logic                       clk_i = 1'b0;
  logic                       srst_i, start_i, cmd_ready_i;
  logic [NUM-1:0][DATA_W-1:0] writedata_i;
  logic [NUM-1:0][ADDR_W-1:0] write_address_i, read_address_i;
  logic [NUM-1:0]             write_enable_i;
  logic [NUM-1:0][DATA_W-1:0] readdata_o;
  logic                       ready_o, overrun_o, cmd_valid_o, cmd_write_o, timeout_o;
  logic [ADDR_W-1:0]          cmd_addr_o;
  logic [DATA_W-1:0]          cmd_wdata_o;
  logic                       rd_valid_i = 1'b0;
  logic [DATA_W-1:0]          rd_data_i  = '0;

  sdram_channel_scheduler #(.NUM(NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .srst_i(srst_i), .start_i(start_i),
    .writedata_i(writedata_i), .write_address_i(write_address_i),
    .write_enable_i(write_enable_i), .read_address_i(read_address_i),
    .readdata_o(readdata_o), .ready_o(ready_o), .overrun_o(overrun_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_write_o(cmd_write_o),
    .cmd_addr_o(cmd_addr_o), .cmd_wdata_o(cmd_wdata_o),
    .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_err = 0;
  int n_chk = 0;

  // Engine model: logs every accepted command, answers reads RD_LAT cycles later
  // with rbase + channel, except for drop_addr which never gets an answer.
  logic [ADDR_W-1:0] drop_addr = '1;
  logic [DATA_W-1:0] rbase = '0;
  logic              xfer_s, wr_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wd_s;
  int                pend_cnt = 0;
  logic [DATA_W-1:0] pend_data;
  logic [38:0]       log_cmd [0:511];
  int                n_cmd = 0;
  int                log_base = 0;

  always @(posedge clk_i) begin
    xfer_s = cmd_valid_o && cmd_ready_i;
    wr_s   = cmd_write_o;
    addr_s = cmd_addr_o;
    wd_s   = cmd_wdata_o;
    #1;
    rd_valid_i = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rd_valid_i = 1'b1;
        rd_data_i  = pend_data;
      end
    end
    if (xfer_s) begin
      if (n_cmd < 512) log_cmd[n_cmd] = {wr_s, addr_s, (wr_s ? wd_s : 16'h0)};
      n_cmd++;
      if (!wr_s && addr_s != drop_addr) begin
        pend_cnt  = RD_LAT - 1;
        pend_data = rbase + DATA_W'(addr_s - 22'h100);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic kick();
    log_base = n_cmd;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
  endtask

  // steps = cycles after the kick until ready_o is seen high (-1 on expiry);
  // prev = readdata_o in the cycle before ready_o rose.
  task automatic wait_ready(output int steps, output logic [63:0] prev);
    steps = -1;
    prev  = readdata_o;
    for (int k = 0; k < 400; k++) begin
      if (ready_o) begin
        steps = k;
        return;
      end
      prev = readdata_o;
      step();
    end
  endtask

  task automatic poll_read(input logic [ADDR_W-1:0] a, output logic found);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (cmd_valid_o && !cmd_write_o && cmd_addr_o == a) begin
        found = 1'b1;
        return;
      end
      step();
    end
  endtask

  function automatic logic [38:0] entry(input int idx);
    return (idx < n_cmd) ? log_cmd[idx] : '1;
  endfunction

  task automatic check_seq(input logic [3:0] we, input int exp_n);
    int idx = log_base;
    check("cmd_count", 64'(n_cmd - log_base), 64'(exp_n));
    for (int c = 0; c < NUM; c++) begin
      check("cmd_read", 64'(entry(idx)), 64'({1'b0, ADDR_W'(22'h100 + c), 16'h0}));
      idx++;
      if (we[c]) begin
        check("cmd_write", 64'(entry(idx)), 64'({1'b1, ADDR_W'(22'h200 + c), DATA_W'(16'hA000 + c)}));
        idx++;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  we;
    logic [15:0] rbase;
    int          ncmd;
    int          lat;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t        vecs [4];
  int          steps;
  logic [63:0] prev, last_rd;
  logic        found, stable;

  initial begin
    vecs[0] = '{4'b1111, 16'h1000, 8, 26, 64'h1003_1002_1001_1000};
    vecs[1] = '{4'b0101, 16'h2000, 6, 24, 64'h2003_2002_2001_2000};
    vecs[2] = '{4'b0000, 16'h3000, 4, 22, 64'h3003_3002_3001_3000};
    vecs[3] = '{4'b1000, 16'hBEE0, 5, 23, 64'hBEE3_BEE2_BEE1_BEE0};

    srst_i = 1'b1;
    start_i = 1'b0;
    cmd_ready_i = 1'b1;
    write_enable_i = '1;
    for (int c = 0; c < NUM; c++) begin
      read_address_i[c]  = ADDR_W'(22'h100 + c);
      write_address_i[c] = ADDR_W'(22'h200 + c);
      writedata_i[c]     = DATA_W'(16'hA000 + c);
    end
    repeat (3) @(posedge clk_i);
    #1;
    srst_i = 1'b0;

    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(cmd_valid_o), 64'd0);
    check("rst_write", 64'(cmd_write_o), 64'd0);
    check("rst_addr", 64'(cmd_addr_o), 64'd0);
    check("rst_wdata", 64'(cmd_wdata_o), 64'd0);
    check("rst_readdata", readdata_o, 64'd0);
    check("rst_overrun", 64'(overrun_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    last_rd = '0;

    for (int v = 0; v < 4; v++) begin
      write_enable_i = vecs[v].we;
      rbase = vecs[v].rbase;
      kick();
      wait_ready(steps, prev);
      check("latency", 64'((steps < 0) ? -1 : steps + 1), 64'(vecs[v].lat));
      check("readdata_held", prev, last_rd);
      check("readdata", readdata_o, vecs[v].exp_rd);
      check("valid_idle", 64'(cmd_valid_o), 64'd0);
      check("overrun_clear", 64'(overrun_o), 64'd0);
      check_seq(vecs[v].we, vecs[v].ncmd);
      last_rd = vecs[v].exp_rd;
      step();
      step();
    end

    // Engine backpressure on R1: command must be held unchanged, then issued exactly once.
    write_enable_i = 4'b1111;
    rbase = 16'h4000;
    kick();
    poll_read(22'h101, found);
    check("r1_seen", 64'(found), 64'd1);
    cmd_ready_i = 1'b0;
    stable = 1'b1;
    repeat (5) begin
      step();
      if (!(cmd_valid_o && !cmd_write_o && cmd_addr_o == 22'h101)) stable = 1'b0;
    end
    check("stall_hold", 64'(stable), 64'd1);
    cmd_ready_i = 1'b1;
    wait_ready(steps, prev);
    check("stall_done", 64'(steps >= 0), 64'd1);
    check("stall_readdata", readdata_o, 64'h4003_4002_4001_4000);
    check_seq(4'b1111, 8);
    last_rd = readdata_o;
    step();

    // start_i mid-pass is ignored but flagged; the flag survives later passes.
    rbase = 16'h6000;
    kick();
    repeat (7) step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_ready(steps, prev);
    check("ovr_latency", 64'((steps < 0) ? -1 : steps + 9), 64'd26);
    check("ovr_flag", 64'(overrun_o), 64'd1);
    check("ovr_readdata", readdata_o, 64'h6003_6002_6001_6000);
    check_seq(4'b1111, 8);
    step();
    rbase = 16'h2000;
    write_enable_i = 4'b0101;
    kick();
    wait_ready(steps, prev);
    check("ovr_sticky", 64'(overrun_o), 64'd1);
    check("ovr_next_readdata", readdata_o, 64'h2003_2002_2001_2000);
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    check("ovr_cleared", 64'(overrun_o), 64'd0);

    // Reset while waiting on channel 2 read data; the late answer must be discarded.
    write_enable_i = 4'b1111;
    rbase = 16'h7000;
    kick();
    poll_read(22'h102, found);
    check("r2_seen", 64'(found), 64'd1);
    step();
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    check("srst_ready", 64'(ready_o), 64'd1);
    check("srst_valid", 64'(cmd_valid_o), 64'd0);
    check("srst_readdata", readdata_o, 64'd0);
    repeat (3) step();
    rbase = 16'h5000;
    kick();
    wait_ready(steps, prev);
    check("post_srst_latency", 64'((steps < 0) ? -1 : steps + 1), 64'd26);
    check("post_srst_held", prev, 64'd0);
    check("post_srst_readdata", readdata_o, 64'h5003_5002_5001_5000);
    check_seq(4'b1111, 8);
    step();

`ifdef SDRAM_SCHED_TIMEOUT_EN
    // Channel 1 read never answered: 63-cycle wait, zero result, write still issued.
    drop_addr = 22'h101;
    rbase = 16'h1000;
    kick();
    wait_ready(steps, prev);
    check("tmo_latency", 64'((steps < 0) ? -1 : steps + 1), 64'd87);
    check("tmo_readdata", readdata_o, 64'h1003_1002_0000_1000);
    check("tmo_flag", 64'(timeout_o), 64'd1);
    check_seq(4'b1111, 8);
    drop_addr = '1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
